// File: rtl/keccak_pad_stream.sv
// keccak_pad_stream
// Streaming Keccak padder/blocker. Collects W-bit message words into a
// RATE_BITS-wide block, applies multi-rate padding (domain byte followed by
// pad10*1) on the final word, and presents each block for XOR-absorb into the
// Keccak-f[1600] state. A message that exactly fills a block is followed by a
// separate pad-only block.
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous, active-high reset
//   i_v_data   message word, byte k at bits [8k+7:8k]
//   i_valid    i_v_data is valid
//   i_last     word is the final word of the message
//   i_v_bytes  valid bytes in the final word (0..W/8), ignored unless i_last
//   o_ready    an input word is accepted this cycle (only while filling)
//   o_v_block  padded rate block, word k at bits [kW+W-1:kW]
//   o_valid    o_v_block is valid
//   o_last     block is the final block of the message
//   i_ready    downstream accepts the block
module keccak_pad_stream #(
  parameter int          RATE_BITS = 1088,
  parameter int          W         = 64,
  parameter logic [7:0]  DSBYTE    = 8'h01
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [W-1:0]           i_v_data,
  input  logic                   i_valid,
  input  logic                   i_last,
  input  logic [$clog2(W/8):0]   i_v_bytes,
  output logic                   o_ready,
  output logic [RATE_BITS-1:0]   o_v_block,
  output logic                   o_valid,
  output logic                   o_last,
  input  logic                   i_ready
);

  localparam int NW    = RATE_BITS / W;
  localparam int WB    = W / 8;
  localparam int NB    = RATE_BITS / 8;
  localparam int CNT_W = $clog2(NW + 1);
  localparam int POS_W = $clog2(NB + 1) + 1;

  // Block that carries nothing but padding: domain byte at 0, 0x80 at the top.
  localparam logic [RATE_BITS-1:0] PAD_BLK =
    {{(RATE_BITS-8){1'b0}}, DSBYTE} | {8'h80, {(RATE_BITS-8){1'b0}}};

  typedef enum logic {S_FILL, S_EMIT} state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pad_pend;
  logic [RATE_BITS-1:0]   r_buf;
  logic                   r_valid;
  logic                   r_last;

  logic [W-1:0]           w_word;
  logic [RATE_BITS-1:0]   w_next;
  logic [POS_W-1:0]       w_pos;
  logic                   w_pos_lt;
  logic                   w_full;

  // Byte position right after the last message byte of this word.
  assign w_pos    = POS_W'(r_cnt) * POS_W'(WB) + POS_W'(i_v_bytes);
  assign w_pos_lt = (w_pos < POS_W'(NB));
  assign w_full   = (r_cnt == CNT_W'(NW - 1));

  // Next buffer contents when the current input word is accepted. The buffer
  // is all-zero at the start of every block, so padding can simply be ORed in.
  always_comb begin
    w_word = i_v_data;
    if (i_last) begin
      for (int k = 0; k < WB; k++) begin
        if (k >= int'(i_v_bytes)) w_word[8*k +: 8] = 8'h00;
      end
    end
    w_next = r_buf;
    for (int s = 0; s < NW; s++) begin
      if (r_cnt == CNT_W'(s)) w_next[s*W +: W] = w_word;
    end
    if (i_last && w_pos_lt) begin
      for (int j = 0; j < NB; j++) begin
        if (w_pos == POS_W'(j)) w_next[8*j +: 8] = w_next[8*j +: 8] | DSBYTE;
      end
      w_next[RATE_BITS-1 -: 8] = w_next[RATE_BITS-1 -: 8] | 8'h80;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FILL;
      r_cnt      <= '0;
      r_pad_pend <= 1'b0;
      r_buf      <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (i_valid) begin
            r_buf <= w_next;
            if (i_last) begin
              r_cnt   <= '0;
              r_state <= S_EMIT;
              r_valid <= 1'b1;
              if (w_pos_lt) begin
                r_last <= 1'b1;
              end else begin
                // Data exactly filled the block: padding goes in a block of its own.
                r_last     <= 1'b0;
                r_pad_pend <= 1'b1;
              end
            end else if (w_full) begin
              r_cnt   <= '0;
              r_state <= S_EMIT;
              r_valid <= 1'b1;
              r_last  <= 1'b0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        S_EMIT: begin
          if (i_ready) begin
            if (r_pad_pend) begin
              r_buf      <= PAD_BLK;
              r_pad_pend <= 1'b0;
              r_last     <= 1'b1;
            end else begin
              r_buf   <= '0;
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_state <= S_FILL;
            end
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Handshake outputs are forced low during the reset cycle itself.
  assign o_ready   = (r_state == S_FILL) && !i_rst;
  assign o_valid   = r_valid && !i_rst;
  assign o_last    = r_last && !i_rst;
  assign o_v_block = r_buf;

endmodule

// File: tb/tb_keccak_pad_stream.sv
module tb_keccak_pad_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default parameters (W=64, RATE_BITS=1088, DSBYTE=0x01)
  logic [63:0]   a_data;
  logic          a_vld, a_lst, a_ready, a_valid, a_last, a_iready;
  logic [3:0]    a_bytes;
  logic [1087:0] a_block;

  // DUT B: W=32, RATE_BITS=576, DSBYTE=0x06
  logic [31:0]   b_data;
  logic          b_vld, b_lst, b_ready, b_valid, b_last, b_iready;
  logic [2:0]    b_bytes;
  logic [575:0]  b_block;

  keccak_pad_stream u_a (
    .i_clk(clk), .i_rst(rst), .i_v_data(a_data), .i_valid(a_vld),
    .i_last(a_lst), .i_v_bytes(a_bytes), .o_ready(a_ready),
    .o_v_block(a_block), .o_valid(a_valid), .o_last(a_last), .i_ready(a_iready)
  );

  keccak_pad_stream #(.RATE_BITS(576), .W(32), .DSBYTE(8'h06)) u_b (
    .i_clk(clk), .i_rst(rst), .i_v_data(b_data), .i_valid(b_vld),
    .i_last(b_lst), .i_v_bytes(b_bytes), .o_ready(b_ready),
    .o_v_block(b_block), .o_valid(b_valid), .o_last(b_last), .i_ready(b_iready)
  );

  typedef struct packed {
    logic [1087:0] d;
    logic          l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk) begin
    if (a_vld && a_lst) assert (a_bytes <= 4'd8) else $error("a_bytes out of range");
    if (b_vld && b_lst) assert (b_bytes <= 3'd4) else $error("b_bytes out of range");
  end

  function automatic logic [7:0] byte_of(int seed, int i);
    return 8'(seed + i);
  endfunction

  // Block whose bytes 0..n-1 hold message bytes off..off+n-1, rest zero.
  function automatic logic [1087:0] blk(int seed, int off, int n);
    logic [1087:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[8*j +: 8] = byte_of(seed, off + j);
    return r;
  endfunction

  task automatic cmp_bit(string nm, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic cmp_blk(string nm, logic [1087:0] act, logic [1087:0] exp);
    int bad;
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      bad = 0;
      for (int j = 135; j >= 0; j--) if (act[8*j +: 8] !== exp[8*j +: 8]) bad = j;
      $display("FAIL %s: byte %0d got %02h want %02h", nm, bad, act[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  task automatic fail_to(string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: got timeout want event", nm);
  endtask

  // Scoreboard monitors: pop one expected block per output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_valid && a_iready) begin
      if (qa.size() == 0) begin
        fail_to("A unexpected block");
      end else begin
        e = qa.pop_front();
        cmp_blk("A block", a_block, e.d);
        cmp_bit("A last", a_last, e.l);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_valid && b_iready) begin
      if (qb.size() == 0) begin
        fail_to("B unexpected block");
      end else begin
        e = qb.pop_front();
        cmp_blk("B block", {512'b0, b_block}, e.d);
        cmp_bit("B last", b_last, e.l);
      end
    end
  end

  // Send a message of nbytes bytes on DUT A. With limit > 0 only the first
  // limit words are sent, none marked last (an interrupted message).
  task automatic a_send(int nbytes, int seed, int limit);
    int nw, t, nsend;
    nw = (nbytes == 0) ? 1 : (nbytes + 7) / 8;
    nsend = (limit > 0) ? limit : nw;
    for (int w = 0; w < nsend; w++) begin
      for (int k = 0; k < 8; k++) a_data[8*k +: 8] = byte_of(seed, 8*w + k);
      a_lst   = (limit <= 0) && (w == nw - 1);
      a_bytes = a_lst ? 4'(nbytes - 8*w) : 4'd0;
      a_vld   = 1'b1;
      t = 0;
      @(negedge clk);
      while (!a_ready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) fail_to("A input accept");
      @(posedge clk);
      #1;
      a_vld = 1'b0;
      a_lst = 1'b0;
    end
  endtask

  task automatic drain(string nm);
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 500) begin
      @(posedge clk);
      t++;
    end
    if (t >= 500) fail_to(nm);
    @(posedge clk);
    #1;
  endtask

  // Hold i_ready low for 5 cycles on each of nblk blocks, checking stability.
  task automatic stall_ctl(int nblk);
    int t;
    for (int b = 0; b < nblk; b++) begin
      t = 0;
      @(negedge clk);
      while (!a_valid && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) fail_to("stall wait valid");
      for (int c = 0; c < 5; c++) begin
        if (c > 0) @(negedge clk);
        cmp_blk("stall hold block", a_block, qa[0].d);
        cmp_bit("stall hold last", a_last, qa[0].l);
        cmp_bit("stall ready low", a_ready, 1'b0);
      end
      @(posedge clk);
      #1 a_iready = 1'b1;
      @(posedge clk);
      #1 a_iready = 1'b0;
    end
    a_iready = 1'b1;
  endtask

  initial begin
    exp_t e;
    int t;
    a_data = '0; a_vld = 0; a_lst = 0; a_bytes = '0; a_iready = 1'b1;
    b_data = '0; b_vld = 0; b_lst = 0; b_bytes = '0; b_iready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_bit("reset o_valid", a_valid, 1'b0);
    cmp_bit("reset o_ready", a_ready, 1'b0);
    cmp_bit("reset o_last", a_last, 1'b0);
    cmp_blk("reset o_v_block", a_block, '0);
    cmp_bit("reset B o_ready", b_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // One full word, last
    e.d = blk(0, 0, 8);
    e.d[8*8 +: 8]   = 8'h01;
    e.d[8*135 +: 8] = 8'h80;
    e.l = 1'b1;
    qa.push_back(e);
    a_send(8, 0, 0);
    @(negedge clk);
    cmp_bit("latency o_valid", a_valid, 1'b1);
    drain("drain one-word");

    // Empty message
    e.d = '0;
    e.d[7:0]        = 8'h01;
    e.d[8*135 +: 8] = 8'h80;
    e.l = 1'b1;
    qa.push_back(e);
    a_send(0, 0, 0);
    drain("drain empty");

    // 135 bytes: domain byte and final pad bit share byte 135
    e.d = blk(8'h10, 0, 135);
    e.d[8*135 +: 8] = 8'h81;
    e.l = 1'b1;
    qa.push_back(e);
    a_send(135, 8'h10, 0);
    drain("drain 135");

    // 136 bytes: full data block then pad-only block
    e.d = blk(8'h20, 0, 136);
    e.l = 1'b0;
    qa.push_back(e);
    e.d = '0;
    e.d[7:0]        = 8'h01;
    e.d[8*135 +: 8] = 8'h80;
    e.l = 1'b1;
    qa.push_back(e);
    a_send(136, 8'h20, 0);
    drain("drain 136");

    // 200 bytes with downstream stalls
    e.d = blk(8'h40, 0, 136);
    e.l = 1'b0;
    qa.push_back(e);
    e.d = blk(8'h40, 136, 64);
    e.d[8*64 +: 8]  = 8'h01;
    e.d[8*135 +: 8] = 8'h80;
    e.l = 1'b1;
    qa.push_back(e);
    a_iready = 1'b0;
    fork
      a_send(200, 8'h40, 0);
      stall_ctl(2);
    join
    drain("drain 200");

    // DUT B: 3-byte message, byte 3 of the word must be masked
    e.d = '0;
    e.d[23:0]      = 24'hCCBBAA;
    e.d[8*3 +: 8]  = 8'h06;
    e.d[8*71 +: 8] = 8'h80;
    e.l = 1'b1;
    qb.push_back(e);
    b_data = 32'hDDCCBBAA; b_lst = 1'b1; b_bytes = 3'd3; b_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!b_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) fail_to("B input accept");
    @(posedge clk);
    #1 b_vld = 1'b0; b_lst = 1'b0;
    drain("drain B");

    // Reset after 5 words of a message, then a clean 8-byte message
    a_send(100, 8'h55, 5);
    rst = 1'b1;
    @(negedge clk);
    cmp_bit("mid-reset o_valid", a_valid, 1'b0);
    cmp_bit("mid-reset o_ready", a_ready, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    e.d = blk(8'h80, 0, 8);
    e.d[8*8 +: 8]   = 8'h01;
    e.d[8*135 +: 8] = 8'h80;
    e.l = 1'b1;
    qa.push_back(e);
    a_send(8, 8'h80, 0);
    drain("drain after reset");

    repeat (5) @(posedge clk);
    @(negedge clk);
    cmp_bit("idle o_valid", a_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
